// File: rtl/instr_loader_pkg.sv
// Shared types and field widths for the serial instruction loader.
package instr_loader_pkg;

  typedef enum logic [1:0] {
    LOAD,
    HOLD,
    ISSUE
  } state_e;

  localparam int OPC_W  = 4;
  localparam int OPND_W = 12;
  localparam int CNT_W  = 5;

endpackage

// File: rtl/btn_debounce.sv
// Button synchronizer, debouncer and rising-edge pulse generator.
module btn_debounce #(
  parameter int DB_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_edge
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_level;
  logic          r_edge;
  logic [CW-1:0] r_cnt;
  logic          w_flip;

  // Level flips on the DB_CYCLES-th consecutive mismatching cycle.
  assign w_flip = (r_sync[1] != r_level) && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '0;
      r_level <= 1'b0;
      r_edge  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      r_edge <= w_flip & r_sync[1];
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_edge  = r_edge;

endmodule

// File: rtl/instr_loader.sv
// Shifts a serial instruction word in on debounced strobes and issues it.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int IW        = 16,
  parameter int DB_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_raw,
  input  logic              data_in,
  input  logic              cpu_ready,
  output logic [OPC_W-1:0]  opcode,
  output logic [OPND_W-1:0] instr,
  output logic              inst_done,
  output logic              btn_edge,
  output logic [CNT_W-1:0]  bit_cnt,
  output logic              overrun
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(IW - 1);

  state_e             r_state;
  state_e             w_next;
  logic [1:0]         r_dsync;
  logic [IW-1:0]      r_shift;
  logic [CNT_W-1:0]   r_cnt;
  logic [OPC_W-1:0]   r_opc;
  logic [OPND_W-1:0]  r_opnd;
  logic               r_ovr;
  logic               w_edge;
  logic               w_level;
  logic               w_shift;
  logic               w_load;
  logic               w_done;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_db (
    .clk    (clk),
    .rst    (rst),
    .i_btn  (btn_raw),
    .o_level(w_level),
    .o_edge (w_edge)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= LOAD;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_shift = 1'b0;
    w_load  = 1'b0;
    w_done  = 1'b0;
    unique case (r_state)
      LOAD: begin
        if (w_edge) begin
          w_shift = 1'b1;
          if (r_cnt == LAST_BIT) w_next = HOLD;
        end
      end
      HOLD: begin
        if (cpu_ready) begin
          w_load = 1'b1;
          w_next = ISSUE;
        end
      end
      ISSUE: begin
        w_done = 1'b1;
        w_next = LOAD;
      end
      default: w_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dsync <= '0;
      r_shift <= '0;
      r_cnt   <= '0;
      r_opc   <= '0;
      r_opnd  <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_dsync <= {r_dsync[0], data_in};
      if (w_shift) begin
        r_shift <= {r_shift[IW-2:0], r_dsync[1]};
        r_cnt   <= r_cnt + 1'b1;
      end
      if (w_load) begin
        r_opc  <= r_shift[IW-1 -: OPC_W];
        r_opnd <= r_shift[OPND_W-1:0];
      end
      if (w_done) r_cnt <= '0;
      // Strobes while a full word waits are dropped but remembered.
      if (w_edge && (r_state != LOAD)) r_ovr <= 1'b1;
    end
  end

  assign opcode    = r_opc;
  assign instr     = r_opnd;
  assign inst_done = w_done;
  assign btn_edge  = w_edge;
  assign bit_cnt   = r_cnt;
  assign overrun   = r_ovr;

  logic w_unused;
  assign w_unused = w_level;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader with DB_CYCLES=4.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_raw = 1'b0;
  logic        data_in = 1'b0;
  logic        cpu_ready = 1'b0;
  logic [3:0]  opcode;
  logic [11:0] instr;
  logic        inst_done;
  logic        btn_edge;
  logic [4:0]  bit_cnt;
  logic        overrun;

  instr_loader #(
    .IW(16),
    .DB_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .data_in  (data_in),
    .cpu_ready(cpu_ready),
    .opcode   (opcode),
    .instr    (instr),
    .inst_done(inst_done),
    .btn_edge (btn_edge),
    .bit_cnt  (bit_cnt),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_edge = 0;
  int n_done = 0;
  int n_consec = 0;
  int edge_cyc = 0;
  int done_cyc = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (btn_edge) begin
      n_edge = n_edge + 1;
      edge_cyc = cyc;
    end
    if (inst_done) begin
      n_done = n_done + 1;
      done_cyc = cyc;
      if (prev_done) n_consec = n_consec + 1;
    end
    prev_done = inst_done;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic press(input logic b);
    @(negedge clk);
    data_in = b;
    btn_raw = 1'b1;
    cycles(8);
    btn_raw = 1'b0;
    cycles(8);
  endtask

  task automatic shift_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) press(w[i]);
  endtask

  typedef struct {
    logic [15:0] word;
    logic [3:0]  exp_op;
    logic [11:0] exp_in;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int d0;
    int e0;
    int bad;

    vecs[0] = '{16'h8A53, 4'h8, 12'hA53};
    vecs[1] = '{16'h1234, 4'h1, 12'h234};
    vecs[2] = '{16'hFFFF, 4'hF, 12'hFFF};
    vecs[3] = '{16'h0000, 4'h0, 12'h000};
    vecs[4] = '{16'h5AC3, 4'h5, 12'hAC3};

    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(1);
    chk("rst_opcode", {28'd0, opcode}, 32'd0);
    chk("rst_instr", {20'd0, instr}, 32'd0);
    chk("rst_flags", {28'd0, inst_done, btn_edge, overrun, 1'b0}, 32'd0);
    chk("rst_bitcnt", {27'd0, bit_cnt}, 32'd0);

    cpu_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      d0 = n_done;
      shift_word(vecs[v].word);
      cycles(4);
      chk("vec_pulses", n_done - d0, 1);
      chk("vec_opcode", {28'd0, opcode}, {28'd0, vecs[v].exp_op});
      chk("vec_instr", {20'd0, instr}, {20'd0, vecs[v].exp_in});
      chk("vec_bitcnt", {27'd0, bit_cnt}, 32'd0);
    end
    chk("vec_overrun", {31'd0, overrun}, 32'd0);

    // Glitches shorter than the debounce window.
    do_reset();
    for (int i = 0; i < 5; i++) press(1'b1);
    e0 = n_edge;
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      btn_raw = 1'b1;
      cycles(3);
      btn_raw = 1'b0;
      cycles(3);
    end
    cycles(6);
    chk("glitch_edges", n_edge - e0, 0);
    chk("glitch_bitcnt", {27'd0, bit_cnt}, 32'd5);
    @(negedge clk);
    btn_raw = 1'b1;
    cycles(8);
    btn_raw = 1'b0;
    cycles(3);
    btn_raw = 1'b1;
    cycles(3);
    btn_raw = 1'b0;
    cycles(10);
    chk("lowglitch_edges", n_edge - e0, 1);
    chk("lowglitch_bitcnt", {27'd0, bit_cnt}, 32'd6);

    // Full word waits while the core is busy.
    do_reset();
    cpu_ready = 1'b0;
    d0 = n_done;
    shift_word(16'h8A53);
    chk("hold_bitcnt", {27'd0, bit_cnt}, 32'd16);
    chk("hold_no_ovr", {31'd0, overrun}, 32'd0);
    press(1'b0);
    press(1'b1);
    cycles(4);
    chk("hold_no_done", n_done - d0, 0);
    chk("hold_overrun", {31'd0, overrun}, 32'd1);
    chk("hold_word", {16'd0, opcode, instr}, 32'd0);
    chk("hold_bitcnt2", {27'd0, bit_cnt}, 32'd16);
    cpu_ready = 1'b1;
    cycles(4);
    chk("release_done", n_done - d0, 1);
    chk("release_word", {16'd0, opcode, instr}, 32'h8A53);
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);

    // Reset mid-word, then a clean word.
    for (int i = 0; i < 7; i++) press(1'b1);
    chk("mid_bitcnt", {27'd0, bit_cnt}, 32'd7);
    do_reset();
    chk("rst_mid_bitcnt", {27'd0, bit_cnt}, 32'd0);
    chk("rst_mid_ovr", {31'd0, overrun}, 32'd0);
    chk("rst_mid_word", {16'd0, opcode, instr}, 32'd0);
    d0 = n_done;
    shift_word(16'h1234);
    cycles(4);
    chk("after_rst_done", n_done - d0, 1);
    chk("after_rst_word", {16'd0, opcode, instr}, 32'h1234);

    // Reset while a word is pending.
    cpu_ready = 1'b0;
    d0 = n_done;
    shift_word(16'hBEEF);
    do_reset();
    cpu_ready = 1'b1;
    cycles(6);
    chk("rst_hold_done", n_done - d0, 0);
    chk("rst_hold_bitcnt", {27'd0, bit_cnt}, 32'd0);

    // Back-to-back words; first word must stay visible.
    d0 = n_done;
    shift_word(16'h1234);
    bad = 0;
    for (int i = 15; i >= 0; i--) begin
      press(1'b1);
      if (i > 0 && {opcode, instr} !== 16'h1234) bad++;
    end
    cycles(4);
    chk("b2b_stable", bad, 0);
    chk("b2b_done", n_done - d0, 2);
    chk("b2b_word", {16'd0, opcode, instr}, 32'hFFFF);

    // cpu_ready rises together with the last strobe.
    cpu_ready = 1'b0;
    d0 = n_done;
    for (int i = 0; i < 15; i++) press(1'b0);
    cpu_ready = 1'b1;
    press(1'b1);
    cycles(4);
    chk("lat_done", n_done - d0, 1);
    chk("lat_cycles", done_cyc - edge_cyc, 2);
    chk("lat_word", {16'd0, opcode, instr}, 32'h0001);

    chk("no_consec_done", n_consec, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
